gcd_operand_feeder: RTL

Upstream front-end for the subtractive GCD core (controller plus datapath). It accepts operand pairs over a valid/ready stream and buffers them in a small FIFO. Each pair is then sequenced into the core's single `data_in` bus in the core's load order: A on the first cycle, B on the second. The block waits for `done`, captures the result, re-arms the core, and presents results downstream over a valid/ready stream. Zero operands never reach the core, because subtraction-based GCD does not terminate on them.

---
 rtl/gcd_operand_feeder.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/gcd_operand_feeder.sv
// Operand-pair FIFO and load sequencer in front of a subtractive GCD core.
// Optional WAIT watchdog is enabled by defining GCD_FEEDER_TIMEOUT_EN.
module gcd_operand_feeder #(
    parameter int WIDTH      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             core_start,
    output logic [WIDTH-1:0] core_data_in,
    output logic             core_clear,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err,
    output logic             busy,
    output logic [2:0]       dbg_state_o
);
    // Handshakes: a transfer happens on a cycle where valid && ready; valid never
    // depends on ready, and payload is held stable while valid && !ready.

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_WAIT   = 3'd3,
        S_CLEAR  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] fifo_a_q [FIFO_DEPTH];
    logic [WIDTH-1:0] fifo_b_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_valid_q, res_valid_d;
    logic             push, pop;
    logic [WIDTH-1:0] head_a, head_b;

`ifdef GCD_FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          res_err_q, res_err_d;
    assign res_err = res_err_q;
`else
    assign res_err = 1'b0;
`endif

    // in_ready uses the registered count only, so a same-cycle pop never opens space.
    assign in_ready    = !rst && (count_q != FULL_CNT);
    assign push        = in_valid && in_ready;
    assign head_a      = fifo_a_q[rd_ptr_q];
    assign head_b      = fifo_b_q[rd_ptr_q];
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign busy        = (state_q != S_IDLE) || (count_q != '0);
    assign dbg_state_o = state_q;

    always_comb begin
        state_d      = state_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        res_valid_d  = res_valid_q && !res_ready;
        res_data_d   = res_data_q;
        pop          = 1'b0;
        core_start   = 1'b0;
        core_data_in = '0;
        core_clear   = rst;
`ifdef GCD_FEEDER_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
        res_err_d    = res_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if ((count_q != '0) && (!res_valid_q || res_ready)) begin
                    pop    = 1'b1;
                    op_a_d = head_a;
                    op_b_d = head_b;
                    // gcd(0,x)=x; the core would never terminate on a zero operand.
                    if ((head_a == '0) || (head_b == '0)) begin
                        res_data_d  = head_a | head_b;
                        res_valid_d = 1'b1;
`ifdef GCD_FEEDER_TIMEOUT_EN
                        res_err_d   = 1'b0;
`endif
                    end else begin
                        state_d = S_LOAD_A;
                    end
                end
            end
            S_LOAD_A: begin
                core_start   = 1'b1;
                core_data_in = op_a_q;
                state_d      = S_LOAD_B;
            end
            S_LOAD_B: begin
                core_data_in = op_b_q;
                state_d      = S_WAIT;
`ifdef GCD_FEEDER_TIMEOUT_EN
                tmo_cnt_d    = '0;
`endif
            end
            S_WAIT: begin
                core_data_in = op_b_q;
`ifdef GCD_FEEDER_TIMEOUT_EN
                tmo_cnt_d    = tmo_cnt_q + 1'b1;
`endif
                if (core_done) begin
                    res_data_d  = core_result;
                    res_valid_d = 1'b1;
                    state_d     = S_CLEAR;
`ifdef GCD_FEEDER_TIMEOUT_EN
                    res_err_d   = 1'b0;
                end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                    res_data_d  = '0;
                    res_valid_d = 1'b1;
                    res_err_d   = 1'b1;
                    state_d     = S_CLEAR;
`endif
                end
            end
            S_CLEAR: begin
                core_clear = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
`ifdef GCD_FEEDER_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            res_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
`ifdef GCD_FEEDER_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            res_err_q   <= res_err_d;
`endif
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (!push && pop) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a_q[wr_ptr_q] <= in_a;
            fifo_b_q[wr_ptr_q] <= in_b;
        end
    end

endmodule
